ram2_burst_master: RTL and testbench

//   Upstream bus master for the 32x32 single-port RAM (ram2): ena/wena/addr plus a shared inout data bus.

---
 rtl/ram2_bus_pkg.sv | 15 +
 rtl/ram2_burst_ctr.sv | 33 +++
 rtl/ram2_burst_master.sv | 111 +++++++++++
 tb/tb_ram2_burst_master.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram2_bus_pkg.sv
// Shared definitions for the ram2 burst master: default widths and controller states.
package ram2_bus_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    TURN,
    WR,
    RD,
    DONE
  } state_t;

endpackage

// File: rtl/ram2_burst_ctr.sv
// Burst address/beat counter: loads a start address and beat count, then steps
// the address (wrapping modulo depth) while counting beats down to the last one.
module ram2_burst_ctr #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_len,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last
);

  logic [ADDR_W-1:0] beats;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr <= '0;
      beats    <= '0;
    end else if (load) begin
      cur_addr <= load_addr;
      beats    <= load_len;
    end else if (adv) begin
      cur_addr <= cur_addr + 1'b1;
      beats    <= beats - 1'b1;
    end
  end

  assign last = (beats == '0);

endmodule

// File: rtl/ram2_burst_master.sv
// Burst master for the single-port ram2: converts valid/ready burst requests into
// registered RAM write/read sequences and owns the shared tristate data bus.
module ram2_burst_master
  import ram2_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  state_t            state;
  logic              we_q;
  logic              drv_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] cur_addr;
  logic              last;
  logic              accept;
  logic              adv;
  logic              rd_cap;

  assign req_ready = (state == IDLE);
  assign wr_ready  = (state == WR);
  assign accept    = req_valid && req_ready;
  assign adv       = ((state == WR) && wr_valid) || (state == RD);
  assign rd_cap    = ram_ena && !ram_wena;

  // The bus is only ever driven from registered state, so turnaround is clean.
  assign ram_data  = drv_q ? wdata_q : {DATA_W{1'bz}};

  ram2_burst_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .adv       (adv),
    .load_addr (req_addr),
    .load_len  (req_len),
    .cur_addr  (cur_addr),
    .last      (last)
  );

  // RAM-side strobes default low every cycle; only active beats raise them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      drv_q    <= 1'b0;
      wdata_q  <= '0;
      ram_ena  <= 1'b0;
      ram_wena <= 1'b0;
      ram_addr <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
    end else begin
      ram_ena  <= 1'b0;
      ram_wena <= 1'b0;
      drv_q    <= 1'b0;
      done     <= 1'b0;
      rd_valid <= rd_cap;
      if (rd_cap) rd_data <= ram_data;
      case (state)
        IDLE: begin
          if (accept) begin
            we_q  <= req_we;
            state <= TURN;
          end
        end
        TURN: state <= we_q ? WR : RD;
        WR: begin
          if (wr_valid) begin
            ram_ena  <= 1'b1;
            ram_wena <= 1'b1;
            ram_addr <= cur_addr;
            drv_q    <= 1'b1;
            wdata_q  <= wr_data;
            if (last) state <= DONE;
          end
        end
        RD: begin
          ram_ena  <= 1'b1;
          ram_addr <= cur_addr;
          if (last) state <= DONE;
        end
        // The final read is captured at this edge, so its strobe lines up with done.
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram2_burst_master.sv
// Directed bench for ram2_burst_master with a behavioural 32x32 ram2 on the shared bus.
module tb_ram2_burst_master;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] req_len = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          req_ready, wr_ready, rd_valid, done;
  logic          ram_ena, ram_wena;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] rd_data;
  wire  [DW-1:0] ram_data;

  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] exp_mem [0:31];
  logic [DW-1:0] wbuf [0:31];
  logic          mem_done = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  int done_cnt = 0, wr_cnt = 0, acc_cnt = 0, cont_err = 0, x_err = 0, coincide = 0;
  logic [DW-1:0] rd_q [$];
  int            rd_cyc [$];
  logic [AW-1:0] addr_log [$];

  always #20 clk = ~clk;

  ram2_burst_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .done      (done),
    .ram_ena   (ram_ena),
    .ram_wena  (ram_wena),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data)
  );

  // ram2 partner: combinational read onto the bus, write at the clock edge.
  assign ram_data = (ram_ena && !ram_wena) ? mem[ram_addr] : {DW{1'bz}};

  always @(posedge clk) begin
    cycle++;
    if (!mem_done) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hDEAD_0000 + i;
      mem_done <= 1'b1;
    end else if (ram_ena && ram_wena) begin
      mem[ram_addr] <= ram_data;
    end
  end

  // Passive monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        rd_q.push_back(rd_data);
        rd_cyc.push_back(cycle);
      end
      if (done) done_cnt++;
      if (rd_valid && done) coincide++;
      if (ram_ena) addr_log.push_back(ram_addr);
      if (ram_ena && ram_wena) wr_cnt++;
      if (req_valid && req_ready) acc_cnt++;
      if (ram_ena && !ram_wena && $isunknown(ram_data)) x_err++;
      if (dut.drv_q && ram_ena && !ram_wena) cont_err++;
    end
  end

  task automatic send_req(input logic we, input logic [AW-1:0] addr,
                          input logic [AW-1:0] len, output bit to);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        to = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic send_beats(input int first, input int n, output bit to);
    bit ok;
    to = 1'b0;
    for (int b = first; b < first + n; b++) begin
      wr_valid = 1'b1;
      wr_data  = wbuf[b];
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (wr_ready) begin
          @(posedge clk);
          #1;
          ok = 1'b1;
          break;
        end
      end
      if (!ok) to = 1'b1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(output bit to);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        @(posedge clk);
        #1;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #10;
    tests_run++;
    if ({ram_ena, ram_wena, ram_addr, rd_valid, rd_data, done, dut.drv_q} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {ram_ena, ram_wena, ram_addr, rd_valid, rd_data, done, dut.drv_q});
    end
    tests_run++;
    if ({req_ready, wr_ready} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b expected 10", {req_ready, wr_ready});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    bit t1, t2, t3, t4, t5;
    int d0;
    logic [DW-1:0] got;
    rd_q.delete();
    d0 = done_cnt;
    wbuf[0] = 32'h0000_0080;
    send_req(1'b1, 5'd2, 5'd0, t1);
    send_beats(0, 1, t2);
    wait_done(t3);
    exp_mem[2] = 32'h0000_0080;
    send_req(1'b0, 5'd2, 5'd0, t4);
    wait_done(t5);
    tests_run++;
    if ({t1, t2, t3, t4, t5} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_timeout: got %b expected 00000", {t1, t2, t3, t4, t5});
    end
    tests_run++;
    if (rd_q.size() !== 1) begin
      tests_failed++;
      $display("[TB] FAIL single_rd_count: got %0d expected 1", rd_q.size());
    end
    got = (rd_q.size() > 0) ? rd_q[0] : 'x;
    tests_run++;
    if (got !== 32'h0000_0080) begin
      tests_failed++;
      $display("[TB] FAIL single_rd_data: got %h expected 00000080", got);
    end
    tests_run++;
    if (done_cnt - d0 !== 2) begin
      tests_failed++;
      $display("[TB] FAIL single_done_count: got %0d expected 2", done_cnt - d0);
    end
  endtask

  task automatic test_wrap_burst;
    bit t1, t2, t3, t4, t5;
    int c0;
    logic [AW-1:0] exp_addr [8];
    exp_addr = '{5'd30, 5'd31, 5'd0, 5'd1, 5'd30, 5'd31, 5'd0, 5'd1};
    rd_q.delete();
    rd_cyc.delete();
    addr_log.delete();
    c0 = coincide;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0A0_0000 + i;
    send_req(1'b1, 5'd30, 5'd3, t1);
    send_beats(0, 4, t2);
    wait_done(t3);
    for (int i = 0; i < 4; i++) exp_mem[(30 + i) % 32] = wbuf[i];
    send_req(1'b0, 5'd30, 5'd3, t4);
    wait_done(t5);
    tests_run++;
    if ({t1, t2, t3, t4, t5} !== 5'b0 || addr_log.size() !== 8 || rd_q.size() !== 4) begin
      tests_failed++;
      $display("[TB] FAIL wrap_shape: got to=%b addrs=%0d reads=%0d expected 0/8/4",
               {t1, t2, t3, t4, t5}, addr_log.size(), rd_q.size());
    end
    for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
      tests_run++;
      if (addr_log[i] !== exp_addr[i]) begin
        tests_failed++;
        $display("[TB] FAIL wrap_addr[%0d]: got %0d expected %0d", i, addr_log[i], exp_addr[i]);
      end
    end
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      tests_run++;
      if (rd_q[i] !== wbuf[i]) begin
        tests_failed++;
        $display("[TB] FAIL wrap_rd[%0d]: got %h expected %h", i, rd_q[i], wbuf[i]);
      end
    end
    for (int i = 1; i < rd_cyc.size(); i++) begin
      tests_run++;
      if (rd_cyc[i] !== rd_cyc[i-1] + 1) begin
        tests_failed++;
        $display("[TB] FAIL wrap_consecutive[%0d]: got cycle %0d expected %0d",
                 i, rd_cyc[i], rd_cyc[i-1] + 1);
      end
    end
    tests_run++;
    if (coincide - c0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL wrap_last_with_done: got %0d expected 1", coincide - c0);
    end
  endtask

  task automatic test_stall;
    bit t1, t2, t3, t4, t5, t6;
    int w0;
    rd_q.delete();
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0B0_0000 + i;
    send_req(1'b1, 5'd10, 5'd3, t1);
    send_beats(0, 2, t2);
    for (int s = 0; s < 2; s++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if ({ram_ena, dut.drv_q} !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL stall_idle_bus[%0d]: got ena,drv=%b expected 00", s, {ram_ena, dut.drv_q});
      end
    end
    send_beats(2, 2, t3);
    wait_done(t4);
    for (int i = 0; i < 4; i++) exp_mem[10 + i] = wbuf[i];
    tests_run++;
    if (wr_cnt - w0 !== 4) begin
      tests_failed++;
      $display("[TB] FAIL stall_write_count: got %0d expected 4", wr_cnt - w0);
    end
    send_req(1'b0, 5'd10, 5'd3, t5);
    wait_done(t6);
    tests_run++;
    if ({t1, t2, t3, t4, t5, t6} !== 6'b0 || rd_q.size() !== 4) begin
      tests_failed++;
      $display("[TB] FAIL stall_shape: got to=%b reads=%0d expected 0/4",
               {t1, t2, t3, t4, t5, t6}, rd_q.size());
    end
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      tests_run++;
      if (rd_q[i] !== wbuf[i]) begin
        tests_failed++;
        $display("[TB] FAIL stall_rd[%0d]: got %h expected %h", i, rd_q[i], wbuf[i]);
      end
    end
  endtask

  task automatic test_reset_abort;
    bit t1, t2, t3, t4;
    int d0;
    rd_q.delete();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0C0_0000 + i;
    send_req(1'b1, 5'd20, 5'd3, t1);
    send_beats(0, 2, t2);
    wr_valid = 1'b1;
    wr_data  = wbuf[2];
    @(posedge clk);
    #1;
    tests_run++;
    if ({ram_ena, ram_wena, ram_addr} !== {2'b11, 5'd22}) begin
      tests_failed++;
      $display("[TB] FAIL abort_beat2_issued: got %b expected 1110110", {ram_ena, ram_wena, ram_addr});
    end
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({ram_ena, ram_wena, ram_addr, rd_valid, rd_data, done, dut.drv_q} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL abort_outputs: got %h expected 0",
               {ram_ena, ram_wena, ram_addr, rd_valid, rd_data, done, dut.drv_q});
    end
    wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (done_cnt - d0 !== 0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_no_done: got done=%0d ready=%b expected 0/1", done_cnt - d0, req_ready);
    end
    exp_mem[20] = wbuf[0];
    exp_mem[21] = wbuf[1];
    send_req(1'b0, 5'd20, 5'd3, t3);
    wait_done(t4);
    tests_run++;
    if ({t1, t2, t3, t4} !== 4'b0 || rd_q.size() !== 4) begin
      tests_failed++;
      $display("[TB] FAIL abort_shape: got to=%b reads=%0d expected 0/4", {t1, t2, t3, t4}, rd_q.size());
    end
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      tests_run++;
      if (rd_q[i] !== exp_mem[20 + i]) begin
        tests_failed++;
        $display("[TB] FAIL abort_rd[%0d]: got %h expected %h", i, rd_q[i], exp_mem[20 + i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int a0, d0, busy;
    bit to;
    logic [DW-1:0] exp;
    rd_q.delete();
    a0 = acc_cnt;
    d0 = done_cnt;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 5'd0;
    req_len   = 5'd7;
    @(negedge clk);
    @(posedge clk);
    #1;
    req_addr = 5'd2;
    req_len  = 5'd0;
    tests_run++;
    if ({ram_ena, req_ready} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL b2b_turn: got ena,ready=%b expected 00", {ram_ena, req_ready});
    end
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) break;
      busy++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    tests_run++;
    if (busy !== 10) begin
      tests_failed++;
      $display("[TB] FAIL b2b_busy_cycles: got %0d expected 10", busy);
    end
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (done_cnt - d0 >= 2) begin
        to = 1'b0;
        break;
      end
    end
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (to !== 1'b0 || acc_cnt - a0 !== 2 || rd_q.size() !== 9) begin
      tests_failed++;
      $display("[TB] FAIL b2b_accepts: got to=%b acc=%0d reads=%0d expected 0/2/9",
               to, acc_cnt - a0, rd_q.size());
    end
    for (int i = 0; i < 9 && i < rd_q.size(); i++) begin
      exp = (i < 8) ? exp_mem[i] : exp_mem[2];
      tests_run++;
      if (rd_q[i] !== exp) begin
        tests_failed++;
        $display("[TB] FAIL b2b_rd[%0d]: got %h expected %h", i, rd_q[i], exp);
      end
    end
  endtask

  task automatic test_full_wrap;
    bit t1, t2;
    rd_q.delete();
    addr_log.delete();
    send_req(1'b0, 5'd5, 5'd31, t1);
    wait_done(t2);
    tests_run++;
    if ({t1, t2} !== 2'b0 || rd_q.size() !== 32 || addr_log.size() !== 32) begin
      tests_failed++;
      $display("[TB] FAIL full_shape: got to=%b reads=%0d addrs=%0d expected 0/32/32",
               {t1, t2}, rd_q.size(), addr_log.size());
    end
    tests_run++;
    if (addr_log.size() > 27 && addr_log[27] !== 5'd0) begin
      tests_failed++;
      $display("[TB] FAIL full_wrap_addr: got %0d expected 0", addr_log[27]);
    end
    for (int i = 0; i < 32 && i < rd_q.size(); i++) begin
      tests_run++;
      if (rd_q[i] !== exp_mem[(5 + i) % 32]) begin
        tests_failed++;
        $display("[TB] FAIL full_rd[%0d]: got %h expected %h", i, rd_q[i], exp_mem[(5 + i) % 32]);
      end
    end
  endtask

  task automatic test_contention;
    tests_run++;
    if (cont_err !== 0 || x_err !== 0) begin
      tests_failed++;
      $display("[TB] FAIL bus_contention: got drive=%0d xread=%0d expected 0/0", cont_err, x_err);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'hDEAD_0000 + i;
    for (int i = 0; i < 32; i++) wbuf[i] = '0;
    test_reset;
    test_single;
    test_wrap_burst;
    test_stall;
    test_reset_abort;
    test_back_to_back;
    test_full_wrap;
    test_contention;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
